seq_play_ctrl: RTL and testbench
================================

// Module: seq_play_ctrl
// PURPOSE
// - Controls tag-list playback for the sequencer. Selects the active sequence from debounced up/down pushbuttons and fetches
//   that sequence's tag word from the 2-port tag RAM. Then steps the ROM address from the tag's start to its end, one step
//   per slow_tick. Sits between the pushbuttons, the RAM read port and the ROM address input.
// PARAMETERS
// - NUM_SEQ     64    number of sequences; seq_num wraps within 0..NUM_SEQ-1
// - DEB_CYCLES  16    cycles a button must be stably high before a press is accepted
// - RD_LAT      2     RAM read latency: cycles from ram_rden to valid ram_q
// PORTS
// - CLK_50          in   1   single clock, 50 MHz; all logic on its rising edge
// - reset           in   1   asynchronous, active-high
// - pb_seq_up       in   1   raw pushbutton, next sequence, already synchronised
// - pb_seq_dn       in   1   raw pushbutton, previous sequence, already synchronised
// - slow_tick       in   1   one-cycle step enable, CLK_50 domain
// - ram_rden        out  1   one-cycle read strobe to tag RAM
// - ram_rdaddress   out  7   tag RAM read address; equals zero-extended seq_num
// - ram_q           in   32  tag word: [9:0] start, [19:10] end, [20] valid, [21] loop
// - rom_addr        out  10  current ROM address
// - rom_addr_valid  out  1   rom_addr is a live playback address
// - seq_num         out  6   active sequence number
// - playing         out  1   high in PLAY
// - tag_err         out  1   sticky; sets on invalid tag or end<start; clears on next fetch
// BEHAVIOUR
// - Reset values: seq_num=0, rom_addr=0, rom_addr_valid=0, playing=0, tag_err=0, ram_rden=0, state=FETCH_REQ.
//   A fetch of sequence 0 therefore starts automatically after reset.
// - Debounce, per button: a counter increments while the input is high and clears when it is low. When the counter
//   reaches DEB_CYCLES, exactly one press pulse is generated. The button re-arms only after it reads low.
// - seq_num, on an up press: seq_num = (seq_num==NUM_SEQ-1) ? 0 : seq_num+1.
// - seq_num, on a down press: seq_num = (seq_num==0) ? NUM_SEQ-1 : seq_num-1.
// - Up and down press pulses in the same cycle: both are ignored and seq_num is unchanged.
// - Any seq_num change, in any state, aborts the current activity in the following cycle:
//   rom_addr_valid=0, playing=0, next state=FETCH_REQ.
// - FSM states and transitions:
//   - FETCH_REQ: ram_rden=1 for exactly 1 cycle, tag_err cleared, then FETCH_WAIT.
//   - FETCH_WAIT: count RD_LAT cycles, then capture ram_q.
//     - If valid=0 or end<start: tag_err=1, go to DONE.
//     - Otherwise: rom_addr=start, rom_addr_valid=1, playing=1, go to PLAY.
//   - PLAY: on slow_tick with rom_addr<end: rom_addr+1.
//     - On slow_tick with rom_addr==end and loop=1: rom_addr=start.
//     - On slow_tick with rom_addr==end and loop=0: rom_addr_valid=0, playing=0, go to DONE.
//       rom_addr holds its last value.
//   - DONE: idle until a seq_num change.
// - Latency: ram_rden to the first valid rom_addr is RD_LAT+1 cycles.
//   A button press crossing DEB_CYCLES to the next ram_rden is 2 cycles.
// - Simultaneous events:
//   - A seq change in the same cycle as a slow_tick: the abort wins and the tick is dropped.
//   - A press during FETCH_WAIT: the in-flight ram_q is discarded and the fetch restarts.
// - Widths: start, end and rom_addr are 10 bits unsigned, with no arithmetic wrap; rom_addr<=end always holds.
//   The tag word is latched in a 32-bit holding register.
// - A reset asserted mid-operation returns all outputs to their reset values immediately.
// STRUCTURE
// - Package seq_pkg holds:
//   - state enum {FETCH_REQ, FETCH_WAIT, PLAY, DONE}
//   - tag field constants TAG_START_LSB=0, TAG_END_LSB=10, TAG_VALID_BIT=20, TAG_LOOP_BIT=21, TAG_ADDR_W=10
// - Sub-module pb_debounce, instantiated twice (up and down buttons):
//   - parameter DEB_CYCLES
//   - ports CLK_50, reset, pb_in, press_pulse
// - Top level contains the seq_num counter, the FSM, the RD_LAT wait counter and the tag holding register.
// TESTING
// - Reset followed by a tag at RAM[0]={loop=0,valid=1,end=5,start=3}:
//   - one ram_rden at address 0;
//   - rom_addr=3,4,5 on successive slow_ticks;
//   - then rom_addr_valid=0, playing=0.
// - Up held for 15 cycles, then released: no seq change.
//   Up held for 40 cycles: exactly one increment, seq_num 0->1, and ram_rdaddress=1.
// - Wrap: at seq_num=0, a down press gives seq_num=63. At seq_num=63, an up press gives seq_num=0.
// - Up and down pulses landing in the same cycle: seq_num is unchanged and no ram_rden is issued.
// - Tag {loop=1,start=10,end=11}: rom_addr steps 10,11,10,11 over 4 ticks.
//   A press during PLAY: refetch and rom_addr_valid=0 in the next cycle.
// - Invalid tag cases:
//   - tag with valid=0: tag_err=1, playing=0;
//   - tag with end=2, start=7: tag_err=1;
//   - a following valid fetch clears tag_err.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and tag-word field positions for the
// sequencer playback controller.
package seq_pkg;

   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,
      FETCH_WAIT = 2'd1,
      PLAY       = 2'd2,
      DONE       = 2'd3
   } state_t;

   localparam int TAG_START_LSB = 0;
   localparam int TAG_END_LSB   = 10;
   localparam int TAG_VALID_BIT = 20;
   localparam int TAG_LOOP_BIT  = 21;
   localparam int TAG_ADDR_W    = 10;

endpackage

// File: rtl/pb_debounce.sv
// Pushbutton debouncer: one press pulse once the input
// has been high for DEB_CYCLES samples; re-arms on low.
module pb_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic CLK_50,
   input  logic reset,
   input  logic pb_in,
   output logic press_pulse
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] LIM = CW'(DEB_CYCLES);
   localparam logic [CW-1:0] ONE = CW'(1);

   logic [CW-1:0] cnt;

   // Counter saturates at LIM so a held button yields one pulse.
   always_ff @(posedge CLK_50 or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         press_pulse <= 1'b0;
      end else begin
         press_pulse <= pb_in && (cnt == LIM - ONE);
         if (!pb_in)
            cnt <= '0;
         else if (cnt != LIM)
            cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/seq_play_ctrl.sv
// Tag-list playback: selects a sequence from the buttons,
// fetches its tag word, then steps the ROM address.
module seq_play_ctrl
   import seq_pkg::*;
#(
   parameter int NUM_SEQ    = 64,
   parameter int DEB_CYCLES = 16,
   parameter int RD_LAT     = 2
) (
   input  logic        CLK_50,
   input  logic        reset,
   input  logic        pb_seq_up,
   input  logic        pb_seq_dn,
   input  logic        slow_tick,
   output logic        ram_rden,
   output logic [6:0]  ram_rdaddress,
   input  logic [31:0] ram_q,
   output logic [9:0]  rom_addr,
   output logic        rom_addr_valid,
   output logic [5:0]  seq_num,
   output logic        playing,
   output logic        tag_err
);

   localparam logic [5:0] SEQ_MAX = 6'(NUM_SEQ - 1);
   localparam logic [3:0] LAT     = 4'(RD_LAT);

   logic up_p;
   logic dn_p;
   logic chg;

   state_t state;
   state_t state_n;

   logic [3:0]  wcnt;
   logic [3:0]  wcnt_n;
   logic [31:0] tag_q;
   logic [31:0] tag_n;
   logic [9:0]  addr_n;
   logic        vld_n;
   logic        play_n;
   logic        err_n;
   logic        rden_n;

   logic [9:0] q_start;
   logic [9:0] q_end;
   logic       q_valid;
   logic [9:0] t_start;
   logic [9:0] t_end;
   logic       t_loop;

   pb_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb_up (
      .CLK_50      (CLK_50),
      .reset       (reset),
      .pb_in       (pb_seq_up),
      .press_pulse (up_p)
   );

   pb_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb_dn (
      .CLK_50      (CLK_50),
      .reset       (reset),
      .pb_in       (pb_seq_dn),
      .press_pulse (dn_p)
   );

   // Coincident up/down pulses cancel out.
   assign chg = up_p ^ dn_p;

   always_ff @(posedge CLK_50 or posedge reset) begin
      if (reset) begin
         seq_num <= '0;
      end else if (up_p && !dn_p) begin
         seq_num <= (seq_num == SEQ_MAX) ? 6'd0 : seq_num + 6'd1;
      end else if (dn_p && !up_p) begin
         seq_num <= (seq_num == 6'd0) ? SEQ_MAX : seq_num - 6'd1;
      end
   end

   assign ram_rdaddress = {1'b0, seq_num};

   assign q_start = ram_q[TAG_START_LSB +: TAG_ADDR_W];
   assign q_end   = ram_q[TAG_END_LSB +: TAG_ADDR_W];
   assign q_valid = ram_q[TAG_VALID_BIT];
   assign t_start = tag_q[TAG_START_LSB +: TAG_ADDR_W];
   assign t_end   = tag_q[TAG_END_LSB +: TAG_ADDR_W];
   assign t_loop  = tag_q[TAG_LOOP_BIT];

   always_ff @(posedge CLK_50 or posedge reset) begin
      if (reset) begin
         state          <= FETCH_REQ;
         wcnt           <= '0;
         tag_q          <= '0;
         rom_addr       <= '0;
         rom_addr_valid <= 1'b0;
         playing        <= 1'b0;
         tag_err        <= 1'b0;
         ram_rden       <= 1'b0;
      end else begin
         state          <= state_n;
         wcnt           <= wcnt_n;
         tag_q          <= tag_n;
         rom_addr       <= addr_n;
         rom_addr_valid <= vld_n;
         playing        <= play_n;
         tag_err        <= err_n;
         ram_rden       <= rden_n;
      end
   end

   // A sequence change overrides every state, including a pending tick.
   always_comb begin
      state_n = state;
      wcnt_n  = wcnt;
      tag_n   = tag_q;
      addr_n  = rom_addr;
      vld_n   = rom_addr_valid;
      play_n  = playing;
      err_n   = tag_err;
      rden_n  = 1'b0;
      if (chg) begin
         state_n = FETCH_REQ;
         vld_n   = 1'b0;
         play_n  = 1'b0;
      end else begin
         unique case (state)
            FETCH_REQ: begin
               rden_n  = 1'b1;
               err_n   = 1'b0;
               wcnt_n  = '0;
               state_n = FETCH_WAIT;
            end
            FETCH_WAIT: begin
               if (wcnt == LAT) begin
                  tag_n = ram_q;
                  if (!q_valid || (q_end < q_start)) begin
                     err_n   = 1'b1;
                     state_n = DONE;
                  end else begin
                     addr_n  = q_start;
                     vld_n   = 1'b1;
                     play_n  = 1'b1;
                     state_n = PLAY;
                  end
               end else begin
                  wcnt_n = wcnt + 4'd1;
               end
            end
            PLAY: begin
               if (slow_tick) begin
                  if (rom_addr < t_end) begin
                     addr_n = rom_addr + 10'd1;
                  end else if (t_loop) begin
                     addr_n = t_start;
                  end else begin
                     vld_n   = 1'b0;
                     play_n  = 1'b0;
                     state_n = DONE;
                  end
               end
            end
            DONE: begin
               state_n = DONE;
            end
            default: begin
               state_n = FETCH_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_play_ctrl.sv
// Directed bench for seq_play_ctrl with a two-cycle
// registered tag RAM model.
module tb_seq_play_ctrl;

   logic        clk;
   logic        reset;
   logic        pb_seq_up;
   logic        pb_seq_dn;
   logic        slow_tick;
   logic        ram_rden;
   logic [6:0]  ram_rdaddress;
   logic [31:0] ram_q;
   logic [9:0]  rom_addr;
   logic        rom_addr_valid;
   logic [5:0]  seq_num;
   logic        playing;
   logic        tag_err;

   logic [31:0] mem [0:127];
   logic [6:0]  addr_r;
   int          rden_cnt;
   int          n_chk;
   int          n_pass;
   int          rb;

   seq_play_ctrl dut (
      .CLK_50         (clk),
      .reset          (reset),
      .pb_seq_up      (pb_seq_up),
      .pb_seq_dn      (pb_seq_dn),
      .slow_tick      (slow_tick),
      .ram_rden       (ram_rden),
      .ram_rdaddress  (ram_rdaddress),
      .ram_q          (ram_q),
      .rom_addr       (rom_addr),
      .rom_addr_valid (rom_addr_valid),
      .seq_num        (seq_num),
      .playing        (playing),
      .tag_err        (tag_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_rden) addr_r <= ram_rdaddress;
      ram_q <= mem[addr_r];
   end

   always @(posedge clk) begin
      if (ram_rden) rden_cnt <= rden_cnt + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk) slow_tick = 1'b1;
      @(negedge clk) slow_tick = 1'b0;
   endtask

   task automatic press(input bit up);
      if (up) pb_seq_up = 1'b1;
      else pb_seq_dn = 1'b1;
      repeat (20) @(negedge clk);
      pb_seq_up = 1'b0;
      pb_seq_dn = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      rden_cnt = 0;
      addr_r = '0;
      ram_q = '0;
      for (int i = 0; i < 128; i++) mem[i] = 32'd0;
      mem[0] = (32'd1 << 20) | (32'd5 << 10) | 32'd3;
      mem[1] = (32'd1 << 21) | (32'd1 << 20) | (32'd11 << 10) | 32'd10;
      mem[2] = (32'd1 << 20) | (32'd2 << 10) | 32'd7;
      mem[3] = (32'd1 << 20);
      pb_seq_up = 1'b0;
      pb_seq_dn = 1'b0;
      slow_tick = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_seq", seq_num, 0);
      check("rst_addr", rom_addr, 0);
      check("rst_vld", rom_addr_valid, 0);
      check("rst_play", playing, 0);
      check("rst_err", tag_err, 0);
      check("rst_rden", ram_rden, 0);
      reset = 1'b0;

      @(negedge clk);
      check("boot_rden", ram_rden, 1);
      check("boot_raddr", ram_rdaddress, 0);
      repeat (6) @(negedge clk);
      check("boot_nrden", rden_cnt, 1);
      check("p0_addr3", rom_addr, 3);
      check("p0_vld", rom_addr_valid, 1);
      check("p0_play", playing, 1);
      tick();
      check("p0_addr4", rom_addr, 4);
      tick();
      check("p0_addr5", rom_addr, 5);
      tick();
      check("p0_end_vld", rom_addr_valid, 0);
      check("p0_end_play", playing, 0);
      check("p0_end_addr", rom_addr, 5);

      pb_seq_up = 1'b1;
      repeat (15) @(negedge clk);
      pb_seq_up = 1'b0;
      repeat (10) @(negedge clk);
      check("short_seq", seq_num, 0);
      check("short_rden", rden_cnt, 1);

      pb_seq_up = 1'b1;
      repeat (40) @(negedge clk);
      pb_seq_up = 1'b0;
      repeat (5) @(negedge clk);
      check("long_seq", seq_num, 1);
      check("long_raddr", ram_rdaddress, 1);
      check("long_rden", rden_cnt, 2);
      check("loop_a10", rom_addr, 10);
      tick();
      check("loop_a11", rom_addr, 11);
      tick();
      check("loop_b10", rom_addr, 10);
      tick();
      check("loop_b11", rom_addr, 11);
      tick();
      check("loop_c10", rom_addr, 10);

      pb_seq_dn = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (seq_num != 6'd1) break;
      end
      check("abort_seq", seq_num, 0);
      check("abort_vld", rom_addr_valid, 0);
      check("abort_play", playing, 0);
      @(negedge clk);
      check("abort_rden", ram_rden, 1);
      pb_seq_dn = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_replay", playing, 1);

      press(1'b0);
      check("wrap_dn", seq_num, 63);
      check("inv_err", tag_err, 1);
      check("inv_play", playing, 0);
      press(1'b1);
      check("wrap_up", seq_num, 0);
      check("inv_clr", tag_err, 0);

      press(1'b1);
      press(1'b1);
      check("rev_seq", seq_num, 2);
      check("rev_err", tag_err, 1);
      check("rev_play", playing, 0);
      press(1'b1);
      check("ok_seq", seq_num, 3);
      check("ok_err", tag_err, 0);
      check("ok_play", playing, 1);
      check("ok_addr", rom_addr, 0);

      rb = rden_cnt;
      pb_seq_up = 1'b1;
      pb_seq_dn = 1'b1;
      repeat (20) @(negedge clk);
      pb_seq_up = 1'b0;
      pb_seq_dn = 1'b0;
      repeat (10) @(negedge clk);
      check("both_seq", seq_num, 3);
      check("both_rden", rden_cnt - rb, 0);
      check("both_play", playing, 1);

      @(negedge clk) reset = 1'b1;
      #1;
      check("mid_rst_seq", seq_num, 0);
      check("mid_rst_vld", rom_addr_valid, 0);
      check("mid_rst_play", playing, 0);
      @(negedge clk) reset = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
